// File: rtl/serial_xfer_ctrl.sv
// serial_xfer_ctrl: SPI mode-0 single-word transfer sequencer driving sclk/cs_n/mosi and capturing miso.
// Build option: define XFER_LSB_FIRST_EN for LSB-first bit order (default MSB first); timing is unchanged.
module serial_xfer_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] tx_data_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             sclk_o,
  output logic             cs_n_o,
  output logic             mosi_o,
  input  logic             miso_i
);

  localparam int HPW = $clog2(CLK_DIV + 1);
  localparam int BCW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [HPW-1:0]   hp_cnt_q, hp_cnt_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             phase_end;
  logic             more_bits;
  logic             rise;

  // Bit-order helpers: the only place the two build variants differ.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
`ifdef XFER_LSB_FIRST_EN
    return w[0];
`else
    return w[WIDTH-1];
`endif
  endfunction

  function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] w);
`ifdef XFER_LSB_FIRST_EN
    return {1'b0, w[WIDTH-1:1]};
`else
    return {w[WIDTH-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [WIDTH-1:0] shift_rx(input logic [WIDTH-1:0] w, input logic b);
`ifdef XFER_LSB_FIRST_EN
    return {b, w[WIDTH-1:1]};
`else
    return {w[WIDTH-2:0], b};
`endif
  endfunction

  assign phase_end = (hp_cnt_q == HPW'(CLK_DIV - 1));
  assign more_bits = (bit_cnt_q < BCW'(WIDTH));

  always_comb begin
    state_d    = state_q;
    hp_cnt_d   = '0;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    rise       = 1'b0;

    if (state_q inside {S_SETUP, S_HIGH, S_LOW})
      hp_cnt_d = phase_end ? '0 : hp_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i && ready_q) begin
          state_d    = S_SETUP;
          tx_shift_d = tx_data_i;
          cs_n_d     = 1'b0;
          ready_d    = 1'b0;
          mosi_d     = first_bit(tx_data_i);
        end
      end
      S_SETUP: begin
        if (phase_end) rise = 1'b1;
      end
      S_HIGH: begin
        if (phase_end) begin
          state_d = S_LOW;
          sclk_d  = 1'b0;
          // After the last bit the low phase is only a hold; mosi stays put.
          if (more_bits) begin
            tx_shift_d = shift_tx(tx_shift_q);
            mosi_d     = first_bit(shift_tx(tx_shift_q));
          end
        end
      end
      S_LOW: begin
        if (phase_end) begin
          if (more_bits) begin
            rise = 1'b1;
          end else begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            rx_data_d = rx_shift_q;
            cs_n_d    = 1'b1;
            mosi_d    = 1'b0;
            bit_cnt_d = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Rising sclk edge: miso is captured on the same clk edge that raises sclk.
    if (rise) begin
      state_d    = S_HIGH;
      sclk_d     = 1'b1;
      rx_shift_d = shift_rx(rx_shift_q, miso_i);
      bit_cnt_d  = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      state_q    <= S_IDLE;
      hp_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_cnt_q   <= hp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign ready_o   = ready_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign sclk_o    = sclk_q;
  assign cs_n_o    = cs_n_q;
  assign mosi_o    = mosi_q;

endmodule
